// File: rtl/seg7_pkg.sv
// Shared types, active-high segment patterns and the hex decode function
// for the multiplexed 7-segment display driver.
package seg7_pkg;

    typedef logic [6:0] seg_t;

    // Bit 0 = segment a ... bit 6 = segment g; 1 = lit.
    localparam seg_t SEG_0   = 7'h3F;
    localparam seg_t SEG_1   = 7'h06;
    localparam seg_t SEG_2   = 7'h5B;
    localparam seg_t SEG_3   = 7'h4F;
    localparam seg_t SEG_4   = 7'h66;
    localparam seg_t SEG_5   = 7'h6D;
    localparam seg_t SEG_6   = 7'h7D;
    localparam seg_t SEG_7   = 7'h07;
    localparam seg_t SEG_8   = 7'h7F;
    localparam seg_t SEG_9   = 7'h6F;
    localparam seg_t SEG_A   = 7'h77;
    localparam seg_t SEG_B   = 7'h7C;
    localparam seg_t SEG_C   = 7'h39;
    localparam seg_t SEG_D   = 7'h5E;
    localparam seg_t SEG_E   = 7'h79;
    localparam seg_t SEG_F   = 7'h71;
    localparam seg_t SEG_OFF = 7'h00;

    function automatic seg_t hex_to_seg(input logic [3:0] nibble);
        seg_t pattern;
        case (nibble)
            4'h0:    pattern = SEG_0;
            4'h1:    pattern = SEG_1;
            4'h2:    pattern = SEG_2;
            4'h3:    pattern = SEG_3;
            4'h4:    pattern = SEG_4;
            4'h5:    pattern = SEG_5;
            4'h6:    pattern = SEG_6;
            4'h7:    pattern = SEG_7;
            4'h8:    pattern = SEG_8;
            4'h9:    pattern = SEG_9;
            4'hA:    pattern = SEG_A;
            4'hB:    pattern = SEG_B;
            4'hC:    pattern = SEG_C;
            4'hD:    pattern = SEG_D;
            4'hE:    pattern = SEG_E;
            default: pattern = SEG_F;
        endcase
        return pattern;
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble to active-high segment pattern decoder.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] i_nibble,
    output seg_t       o_seg
);

    assign o_seg = hex_to_seg(i_nibble);

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit hex display driver with valid/ready input and
// frame-aligned commits. Optional macro: SEG7_LEADING_ZERO_BLANK_EN.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int N_DIGITS    = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [4*N_DIGITS-1:0]   in_data,
    input  logic [N_DIGITS-1:0]     in_blank,
    output logic [6:0]              seg,
    output logic [N_DIGITS-1:0]     an,
    output logic                    frame_done
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);
    localparam logic POL = (ACTIVE_LOW != 0);

    logic [CNT_W-1:0]        r_tick_cnt;
    logic [IDX_W-1:0]        r_digit_idx;
    logic                    r_pending;
    logic [4*N_DIGITS-1:0]   r_shadow_data;
    logic [N_DIGITS-1:0]     r_shadow_blank;
    logic [4*N_DIGITS-1:0]   r_active_data;
    logic [N_DIGITS-1:0]     r_active_blank;
    seg_t                    r_seg;
    logic [N_DIGITS-1:0]     r_an;

    logic                    w_tick;
    logic                    w_frame_end;
    logic                    w_xfer;
    logic                    w_commit;
    logic [N_DIGITS-1:0]     w_commit_blank;
    logic [3:0]              w_nibbles [N_DIGITS];
    logic [N_DIGITS-1:0]     w_an_onehot;
    seg_t                    w_dec_seg;
    seg_t                    w_cur_seg;

    assign w_tick      = (r_tick_cnt == CNT_LAST);
    assign w_frame_end = w_tick && (r_digit_idx == IDX_LAST);
    assign w_xfer      = in_valid && !r_pending;
    // Transfer and commit are exclusive: one needs pending clear, the other set.
    assign w_commit    = w_frame_end && r_pending;

    genvar gi;
    generate
        for (gi = 0; gi < N_DIGITS; gi++) begin : g_digit
            assign w_nibbles[gi]   = r_active_data[4*gi +: 4];
            assign w_an_onehot[gi] = (r_digit_idx == IDX_W'(gi));
        end
    endgenerate

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    logic [N_DIGITS-1:0] w_lz_mask;
    logic                w_seen_nz;

    // Walk from the top digit down; digits above the first nonzero nibble go dark.
    always_comb begin
        w_lz_mask = '0;
        w_seen_nz = 1'b0;
        for (int k = N_DIGITS - 1; k >= 1; k--) begin
            if (r_shadow_data[4*k +: 4] != 4'h0) begin
                w_seen_nz = 1'b1;
            end
            w_lz_mask[k] = !w_seen_nz;
        end
    end

    assign w_commit_blank = r_shadow_blank | w_lz_mask;
`else
    assign w_commit_blank = r_shadow_blank;
`endif

    seg7_hex_decode u_decode (
        .i_nibble (w_nibbles[r_digit_idx]),
        .o_seg    (w_dec_seg)
    );

    assign w_cur_seg = r_active_blank[r_digit_idx] ? SEG_OFF : w_dec_seg;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tick_cnt  <= '0;
            r_digit_idx <= '0;
        end else if (w_tick) begin
            r_tick_cnt  <= '0;
            r_digit_idx <= (r_digit_idx == IDX_LAST) ? '0 : r_digit_idx + IDX_W'(1);
        end else begin
            r_tick_cnt  <= r_tick_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending      <= 1'b0;
            r_shadow_data  <= '0;
            r_shadow_blank <= '0;
            r_active_data  <= '0;
            r_active_blank <= '1;
        end else if (w_xfer) begin
            r_shadow_data  <= in_data;
            r_shadow_blank <= in_blank;
            r_pending      <= 1'b1;
        end else if (w_commit) begin
            r_active_data  <= r_shadow_data;
            r_active_blank <= w_commit_blank;
            r_pending      <= 1'b0;
        end
    end

    // Polarity is applied only here so all internal logic stays active-high.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_seg <= SEG_OFF ^ {7{POL}};
            r_an  <= {N_DIGITS{POL}};
        end else begin
            r_seg <= w_cur_seg ^ {7{POL}};
            r_an  <= w_an_onehot ^ {N_DIGITS{POL}};
        end
    end

    assign in_ready   = !r_pending;
    assign frame_done = w_frame_end;
    assign seg        = r_seg;
    assign an         = r_an;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with N_DIGITS=4, REFRESH_DIV=4, ACTIVE_LOW=1.
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [3:0]  in_blank;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        frame_done;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    seg7_scan_driver #(
        .N_DIGITS    (4),
        .REFRESH_DIV (4),
        .ACTIVE_LOW  (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_blank   (in_blank),
        .seg        (seg),
        .an         (an),
        .frame_done (frame_done)
    );

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s at cycle %0d: observed %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    // Cycle 0 is the first cycle after reset; outputs lag the digit index by one cycle.
    function automatic logic [3:0] exp_an(input int c);
        logic [3:0] one;
        if (c == 0) return 4'hF;
        one = 4'b0001 << (((c - 1) / 4) % 4);
        return ~one;
    endfunction

    function automatic logic [31:0] exp_fd(input int c);
        return (c % 16 == 15) ? 32'd1 : 32'd0;
    endfunction

    task automatic idle_dark(input string tag, input int upto);
        while (cyc <= upto) begin
            check({tag, "_seg"}, 32'(seg), 32'h7F);
            check({tag, "_an"}, 32'(an), 32'(exp_an(cyc)));
            check({tag, "_frame_done"}, 32'(frame_done), exp_fd(cyc));
            check({tag, "_ready"}, 32'(in_ready), 32'd1);
            step();
        end
    endtask

    task automatic show_frame(input string tag, input logic [6:0] s0, input logic [6:0] s1,
                              input logic [6:0] s2, input logic [6:0] s3);
        logic [6:0] s [4];
        s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
        while (cyc % 16 != 1) step();
        for (int j = 0; j < 16; j++) begin
            check({tag, "_an"}, 32'(an), 32'(exp_an(cyc)));
            check({tag, "_seg"}, 32'(seg), 32'(s[j / 4]));
            check({tag, "_frame_done"}, 32'(frame_done), exp_fd(cyc));
            step();
        end
        $display("frame %s checked", tag);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 16'h0;
        in_blank = 4'h0;
        step(); step(); step();
        check("rst_seg", 32'(seg), 32'h7F);
        check("rst_an", 32'(an), 32'hF);
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        rst = 1'b0;
        cyc = 0;
        $display("reset released");

        idle_dark("idle", 40);

        // First word, then a second word held back until the first commits.
        in_valid = 1'b1; in_data = 16'h12AF; in_blank = 4'b0000;
        check("w1_ready", 32'(in_ready), 32'd1);
        $display("offer data=%h blank=%b at cycle %0d", in_data, in_blank, cyc);
        step();
        check("w1_taken", 32'(in_ready), 32'd0);
        in_data = 16'h8888; in_blank = 4'b0101;
        $display("offer data=%h blank=%b at cycle %0d", in_data, in_blank, cyc);
        while (cyc < 48) begin
            check("w2_stall", 32'(in_ready), 32'd0);
            check("dark_pre_commit", 32'(seg), 32'h7F);
            check("stall_frame_done", 32'(frame_done), exp_fd(cyc));
            step();
        end
        check("w2_ready_after_commit", 32'(in_ready), 32'd1);
        step();
        check("w2_taken", 32'(in_ready), 32'd0);
        in_valid = 1'b0; in_data = 16'h0; in_blank = 4'h0;

        show_frame("w1", 7'h0E, 7'h08, 7'h24, 7'h79);
        show_frame("w2", 7'h7F, 7'h00, 7'h7F, 7'h00);
        check("idle_ready", 32'(in_ready), 32'd1);

        // Reset mid-frame while a word is pending: it must never be shown.
        in_valid = 1'b1; in_data = 16'h3333; in_blank = 4'h0;
        $display("offer data=%h blank=%b at cycle %0d", in_data, in_blank, cyc);
        step();
        in_valid = 1'b0;
        step(); step();
        check("rst_pending", 32'(in_ready), 32'd0);
        rst = 1'b1;
        step();
        check("mid_rst_ready", 32'(in_ready), 32'd1);
        check("mid_rst_seg", 32'(seg), 32'h7F);
        check("mid_rst_an", 32'(an), 32'hF);
        check("mid_rst_frame_done", 32'(frame_done), 32'd0);
        rst = 1'b0;
        cyc = 0;
        $display("mid-frame reset released");
        idle_dark("post_rst", 40);

        in_valid = 1'b1; in_data = 16'h0050; in_blank = 4'h0;
        $display("offer data=%h blank=%b at cycle %0d", in_data, in_blank, cyc);
        step();
        in_valid = 1'b0;
        check("lz_taken", 32'(in_ready), 32'd0);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        show_frame("lz", 7'h40, 7'h12, 7'h7F, 7'h7F);
`else
        show_frame("lz", 7'h40, 7'h12, 7'h40, 7'h40);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
